// File: rtl/registrador_letreiro_if.sv
// Control and display bus of the scrolling message register.
// The master drives the mode/pattern/rate controls.
// The slave (the register itself) returns the window, the ring and the step/wrap pulses.
interface registrador_letreiro_if #(
    parameter int WIDTH = 16,
    parameter int WIN   = 7,
    parameter int DIV_W = 8
);
    localparam int PW = $clog2(WIDTH);

    logic             ch0;
    logic             ch1;
    logic             dir;
    logic             pat_sel;
    logic [WIDTH-1:0] data_in;
    logic [DIV_W-1:0] div;
    logic [WIN-1:0]   saida;
    logic [WIDTH-1:0] ring_q;
    logic [PW-1:0]    pos;
    logic             step;
    logic             wrap;

    modport master (
        output ch0, ch1, dir, pat_sel, data_in, div,
        input  saida, ring_q, pos, step, wrap
    );

    modport slave (
        input  ch0, ch1, dir, pat_sel, data_in, div,
        output saida, ring_q, pos, step, wrap
    );
endinterface

// File: rtl/registrador_letreiro.sv
// Rotating message register for the scrolling display panel.
// It holds a WIDTH-bit ring pattern and shows its top WIN bits as the visible window.
// The ring can be held, loaded, rotated continuously or scrolled ping-pong.
// A prescaler sets the scroll rate: one step every div+1 clock cycles.
module registrador_letreiro #(
    parameter int               WIDTH = 16,
    parameter int               WIN   = 7,
    parameter logic [WIDTH-1:0] INIT  = 16'b1010_1110_1110_1110,
    parameter int               DIV_W = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    registrador_letreiro_if.slave bus
);
    localparam int            PW      = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_MAX = PW'(WIDTH - 1);
    localparam logic [PW-1:0] PP_TURN = PW'(WIDTH - WIN);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_ROT  = 2'b10,
        MODE_PP   = 2'b11
    } mode_t;

    typedef enum logic {
        PP_LEFT  = 1'b0,
        PP_RIGHT = 1'b1
    } pp_dir_t;

    mode_t            mode;
    pp_dir_t          pp_dir, pp_nxt;
    logic [WIDTH-1:0] ring, ring_nxt;
    logic [PW-1:0]    pos, pos_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic             step, step_nxt;
    logic             wrap, wrap_nxt;
    logic             move_right;

    assign mode = mode_t'({bus.ch1, bus.ch0});

    assign bus.saida  = ring[WIDTH-1 -: WIN];
    assign bus.ring_q = ring;
    assign bus.pos    = pos;
    assign bus.step   = step;
    assign bus.wrap   = wrap;

    // State register: ring, offset, prescaler, ping-pong direction and the registered pulses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ring   <= INIT;
            pos    <= '0;
            cnt    <= '0;
            pp_dir <= PP_LEFT;
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            ring   <= ring_nxt;
            pos    <= pos_nxt;
            cnt    <= cnt_nxt;
            pp_dir <= pp_nxt;
            step   <= step_nxt;
            wrap   <= wrap_nxt;
        end
    end

    // Next state: a tick is cnt >= div, so lowering div mid-count never stalls; ping-pong reverses without a dwell step
    always_comb begin
        ring_nxt   = ring;
        pos_nxt    = pos;
        cnt_nxt    = cnt;
        pp_nxt     = pp_dir;
        step_nxt   = 1'b0;
        wrap_nxt   = 1'b0;
        move_right = 1'b0;
        unique case (mode)
            MODE_HOLD: begin
                cnt_nxt = '0;
            end
            MODE_LOAD: begin
                ring_nxt = bus.pat_sel ? bus.data_in : INIT;
                pos_nxt  = '0;
                cnt_nxt  = '0;
                pp_nxt   = PP_LEFT;
            end
            MODE_ROT, MODE_PP: begin
                if (cnt >= bus.div) begin
                    cnt_nxt = '0;
                    if (mode == MODE_ROT) begin
                        move_right = bus.dir;
                    end else if (pp_dir == PP_LEFT && pos >= PP_TURN) begin
                        move_right = 1'b1;
                        pp_nxt     = PP_RIGHT;
                    end else if (pp_dir == PP_RIGHT && pos == '0) begin
                        move_right = 1'b0;
                        pp_nxt     = PP_LEFT;
                    end else begin
                        move_right = (pp_dir == PP_RIGHT);
                    end
                    if (move_right) begin
                        ring_nxt = {ring[0], ring[WIDTH-1:1]};
                        pos_nxt  = (pos == '0) ? POS_MAX : pos - 1'b1;
                    end else begin
                        ring_nxt = {ring[WIDTH-2:0], ring[WIDTH-1]};
                        pos_nxt  = (pos == POS_MAX) ? '0 : pos + 1'b1;
                    end
                    step_nxt = 1'b1;
                    wrap_nxt = (pos_nxt == '0);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_registrador_letreiro.sv
// Self-checking bench for registrador_letreiro (WIDTH=16, WIN=7, div up to 8 bits).
// Stimulus pushes the expected step results, stamped with their cycle, into a scoreboard.
// A monitor pops an entry on every step pulse and compares it against the DUT.
module tb_registrador_letreiro;
    localparam logic [15:0] INIT = 16'b1010_1110_1110_1110;

    typedef struct {
        int          cyc;
        logic [15:0] ring;
        logic [3:0]  pos;
        logic        wrap;
        string       name;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base;
    exp_t sbq[$];
    exp_t mon_e;
    int   pp_seq [37] = '{1,2,3,4,5,6,7,8,9,8,7,6,5,4,3,2,1,0,
                          1,2,3,4,5,6,7,8,9,8,7,6,5,4,3,2,1,0,1};

    registrador_letreiro_if #(.WIDTH(16), .WIN(7), .DIV_W(8)) bus ();

    registrador_letreiro #(.WIDTH(16), .WIN(7), .INIT(INIT), .DIV_W(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Free-running edge counter used to time-stamp expected steps
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        logic [31:0] d;
        d = {v, v};
        return d[31 - (n % 16) -: 16];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic d, input logic ps,
                                 input logic [15:0] data, input logic [7:0] dv);
        bus.ch1     = mode[1];
        bus.ch0     = mode[0];
        bus.dir     = d;
        bus.pat_sel = ps;
        bus.data_in = data;
        bus.div     = dv;
    endtask

    task automatic pushExp(input int c, input logic [15:0] r, input logic [3:0] p,
                           input logic w, input string nm);
        exp_t e;
        e.cyc  = c;
        e.ring = r;
        e.pos  = p;
        e.wrap = w;
        e.name = nm;
        sbq.push_back(e);
    endtask

    // Monitor: every step pulse must match the oldest expected entry, in cycle and content
    always @(negedge CLK) begin
        if (RST_N) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                mon_e = sbq.pop_front();
                checkOutput($sformatf("missed_step_%s_at_%0d", mon_e.name, mon_e.cyc), 32'(cyc), 32'(mon_e.cyc));
            end
            if (bus.step) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_step_pos", 32'(bus.pos), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput($sformatf("%s_cycle", mon_e.name), 32'(cyc), 32'(mon_e.cyc));
                    checkOutput($sformatf("%s_ring@%0d", mon_e.name, cyc), 32'(bus.ring_q), 32'(mon_e.ring));
                    checkOutput($sformatf("%s_pos@%0d", mon_e.name, cyc), 32'(bus.pos), 32'(mon_e.pos));
                    checkOutput($sformatf("%s_wrap@%0d", mon_e.name, cyc), 32'(bus.wrap), 32'(mon_e.wrap));
                    checkOutput($sformatf("%s_saida@%0d", mon_e.name, cyc), 32'(bus.saida), 32'(mon_e.ring[15 -: 7]));
                end
            end else if (bus.wrap) begin
                checkOutput("wrap_without_step", 32'(bus.wrap), 32'd0);
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        RST_N = 1'b0;
        applyStimulus(2'b00, 1'b0, 1'b0, 16'h0000, 8'd0);
        repeat (2) @(negedge CLK);
        checkOutput("reset_saida", 32'(bus.saida), 32'(7'b1010111));
        checkOutput("reset_ring", 32'(bus.ring_q), 32'(16'hAEEE));
        checkOutput("reset_pos", 32'(bus.pos), 32'd0);
        checkOutput("reset_step", 32'(bus.step), 32'd0);
        checkOutput("reset_wrap", 32'(bus.wrap), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Rotate left, div=0: a full revolution back to INIT
        base = cyc;
        applyStimulus(2'b10, 1'b0, 1'b0, 16'h0000, 8'd0);
        for (int k = 1; k <= 16; k++) pushExp(base + k, rotl(INIT, k), 4'(k % 16), (k == 16), "rotl");
        @(negedge CLK);
        checkOutput("rotl_first_ring", 32'(bus.ring_q), 32'(16'h5DDD));
        checkOutput("rotl_first_saida", 32'(bus.saida), 32'(7'b0101110));
        checkOutput("rotl_first_pos", 32'(bus.pos), 32'd1);
        checkOutput("rotl_first_step", 32'(bus.step), 32'd1);
        repeat (15) @(negedge CLK);
        checkOutput("rotl_back_to_init", 32'(bus.ring_q), 32'(INIT));
        checkOutput("rotl_wrap_high", 32'(bus.wrap), 32'd1);
        applyStimulus(2'b00, 1'b0, 1'b0, 16'h0000, 8'd0);
        @(negedge CLK);
        checkOutput("rotl_wrap_one_cycle", 32'(bus.wrap), 32'd0);

        // Rotate right, div=3, then lower div to 1 while cnt=2
        base = cyc;
        applyStimulus(2'b10, 1'b1, 1'b0, 16'h0000, 8'd3);
        pushExp(base + 4,  16'h5777,        4'd15, 1'b0, "rotr");
        pushExp(base + 8,  rotl(INIT, 14),  4'd14, 1'b0, "rotr");
        pushExp(base + 11, rotl(INIT, 13),  4'd13, 1'b0, "rotr_divdrop");
        pushExp(base + 13, rotl(INIT, 12),  4'd12, 1'b0, "rotr_div1");
        repeat (10) @(negedge CLK);
        bus.div = 8'd1;
        repeat (3) @(negedge CLK);
        applyStimulus(2'b00, 1'b1, 1'b0, 16'h0000, 8'd1);
        checkOutput("rotr_end_pos", 32'(bus.pos), 32'd12);

        // Walk left from pos 12 to pos 5
        base = cyc;
        applyStimulus(2'b10, 1'b0, 1'b0, 16'h0000, 8'd0);
        for (int k = 1; k <= 9; k++) pushExp(base + k, rotl(INIT, (12 + k) % 16), 4'((12 + k) % 16), ((12 + k) % 16 == 0), "walk");
        repeat (9) @(negedge CLK);
        checkOutput("walk_pos", 32'(bus.pos), 32'd5);

        // External load, then hold with a different data_in present
        applyStimulus(2'b01, 1'b0, 1'b1, 16'hF00F, 8'd0);
        @(negedge CLK);
        checkOutput("load_ring", 32'(bus.ring_q), 32'(16'hF00F));
        checkOutput("load_pos", 32'(bus.pos), 32'd0);
        checkOutput("load_step", 32'(bus.step), 32'd0);
        applyStimulus(2'b00, 1'b0, 1'b1, 16'h1234, 8'd0);
        repeat (10) @(negedge CLK);
        checkOutput("hold_ring", 32'(bus.ring_q), 32'(16'hF00F));
        checkOutput("hold_pos", 32'(bus.pos), 32'd0);

        // Ping-pong, div=0, two full periods plus one step
        base = cyc;
        applyStimulus(2'b11, 1'b0, 1'b0, 16'h0000, 8'd0);
        for (int k = 0; k < 37; k++) pushExp(base + k + 1, rotl(16'hF00F, pp_seq[k]), 4'(pp_seq[k]), (pp_seq[k] == 0), "pingpong");
        repeat (37) @(negedge CLK);
        applyStimulus(2'b00, 1'b0, 1'b0, 16'h0000, 8'd0);
        checkOutput("pp_end_pos", 32'(bus.pos), 32'd1);

        // Reload INIT, rotate with div=5, reset at cnt=3 pos=6
        applyStimulus(2'b01, 1'b0, 1'b0, 16'h0000, 8'd0);
        @(negedge CLK);
        checkOutput("reload_init", 32'(bus.ring_q), 32'(INIT));
        base = cyc;
        applyStimulus(2'b10, 1'b0, 1'b0, 16'h0000, 8'd5);
        for (int k = 1; k <= 6; k++) pushExp(base + 6 * k, rotl(INIT, k), 4'(k), 1'b0, "div5");
        repeat (39) @(negedge CLK);
        checkOutput("pre_reset_pos", 32'(bus.pos), 32'd6);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("async_reset_ring", 32'(bus.ring_q), 32'(INIT));
        checkOutput("async_reset_saida", 32'(bus.saida), 32'(7'b1010111));
        checkOutput("async_reset_pos", 32'(bus.pos), 32'd0);
        checkOutput("async_reset_step", 32'(bus.step), 32'd0);
        checkOutput("async_reset_wrap", 32'(bus.wrap), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        base = cyc;
        pushExp(base + 6, rotl(INIT, 1), 4'd1, 1'b0, "after_reset");
        repeat (6) @(negedge CLK);
        applyStimulus(2'b00, 1'b0, 1'b0, 16'h0000, 8'd5);
        repeat (3) @(negedge CLK);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
